upstream_sched: RTL and testbench
=================================

// Module: upstream_sched
// PURPOSE
// - Round-robin scheduler sharing one upstream_busif among NREQ DMA requesters.
// - Splits each request into chunks of at most MAX_CHUNK bytes.
// - Drives the busif start/done level handshake and throttles it via pause from the aligner FIFO fill level.
// - Sits between the requester descriptor registers and upstream_busif.
// PARAMETERS
// NREQ       4       number of requesters (2..8)
// MAX_CHUNK  2048    max bytes per busif transfer; a multiple of 8, at most 32768
// PAUSE_THR  4       pause asserted while fifo_space < PAUSE_THR (qwords)
// PORTS
// clk         in   1         clock
// rst_n       in   1         reset, asynchronous, active-low
// req_valid   in   NREQ      request pending; held until matching req_ack
// req_addr    in   NREQ*32   byte source address; requester i uses [32i+31:32i]
// req_len     in   NREQ*16   byte length; requester i uses [16i+15:16i]
// req_ack     out  NREQ      1-cycle pulse when requester i's whole request has completed
// busy        out  1         a grant is active
// grant_id    out  3         index of the granted requester; valid while busy
// fifo_space  in   8         free qwords in the aligner FIFO
// bif_start   out  1         to busif start
// bif_pause   out  1         to busif pause
// bif_done    in   1         from busif done
// bif_addr    out  32        to busif src_addr; stable while bif_start or bif_done is high
// bif_length  out  16        to busif src_length; same stability rule as bif_addr
// BEHAVIOUR
// - Reset values: all outputs 0; rr_ptr=0; state=IDLE.
// - IDLE:
//   - Scan req_valid starting from rr_ptr, wrapping modulo NREQ.
//   - On the first set bit k: latch cur_addr=req_addr[k] and rem=req_len[k]; set grant_id=k and busy=1; go LOAD.
//   - Arbitration takes 1 cycle.
// - LOAD:
//   - If rem==0, go ACK.
//   - Otherwise set chunk=min(rem,MAX_CHUNK), drive bif_addr=cur_addr and bif_length=chunk, set bif_start=1, go RUN.
// - RUN:
//   - Hold bif_start=1 until bif_done==1.
//   - On bif_done: bif_start<=0, cur_addr<=cur_addr+chunk (32-bit, wraps modulo 2^32), rem<=rem-chunk; go CLR.
// - CLR:
//   - Wait for bif_done==0.
//   - Then go LOAD if rem!=0, else go ACK.
//   - Never reassert bif_start while bif_done is high.
// - ACK:
//   - Pulse req_ack[grant_id] for 1 cycle; busy<=0; rr_ptr<=(grant_id+1) mod NREQ; go IDLE.
//   - The requester deasserting req_valid in the cycle after ack is legal; no re-grant in the ack cycle.
// - Boundary: req_len==0 gives an ack 3 cycles after valid, with no busif activity.
// - Chunk arithmetic: cur_addr is not required to be aligned; the busif handles the byte offset.
//   - Chunks after the first start at cur_addr+k*MAX_CHUNK.
// - bif_pause:
//   - Registered: bif_pause <= (fifo_space < PAUSE_THR), evaluated every cycle in every state.
//   - 1-cycle latency from fifo_space.
// - A req_valid drop mid-grant is ignored; the grant runs to completion.
// - Simultaneous requests: strict round-robin from rr_ptr; the lower index wins only when it is at or after rr_ptr in wrap order.
// - Asynchronous reset mid-transfer aborts immediately; the busif is reset by the same rst_n.
// - The sim-only state string follows the busif convention.
// STRUCTURE
// - Shared package upstream_pkg: state encodings (IDLE/LOAD/RUN/CLR/ACK, 3 bits) and MAX_CHUNK default.
// - One sub-module, upstream_rr_arb: combinational round-robin NREQ picker (req vector, rr_ptr -> found, idx).
// - The scheduler FSM and datapath stay in this module.
// TESTING
// - req_valid=0001, addr=0x1000, len=64, busif model done after 10 cycles -> one start, bif_addr=0x1000, bif_length=64, req_ack[0] pulse.
// - len=5000, MAX_CHUNK=2048, addr=0x2003 -> three transfers:
//   - 0x2003/2048, then 0x2803/2048, then 0x3003/904.
//   - One ack, after the third done clears.
// - req_valid=1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0; rr_ptr=2 start -> 2,3,0,1.
// - len=0 on req 1 -> req_ack[1] with bif_start never asserted; busy high for exactly 2 cycles.
// - fifo_space 10 -> 3 -> 10 during RUN, PAUSE_THR=4 -> bif_pause high for the same duration, delayed 1 cycle.
// - rst_n low during RUN -> all outputs 0 asynchronously; after release, a pending req is re-granted from rr_ptr=0.
// - Busif model holds bif_done high 5 cycles after start drop -> bif_start is not reasserted until 1 cycle after done falls.

Source files
------------

// File: rtl/upstream_pkg.sv
// Shared types and defaults for the upstream scheduler: FSM encoding and
// chunk sizing helpers.
package upstream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_CLR  = 3'd3,
    ST_ACK  = 3'd4
  } sched_state_e;

  localparam int NREQ_DEFAULT      = 4;
  localparam int MAX_CHUNK_DEFAULT = 2048;
  localparam int PAUSE_THR_DEFAULT = 4;

  // Next busif transfer size: whatever remains, capped at the chunk limit.
  function automatic logic [15:0] chunk_of(input logic [15:0] rem,
                                           input logic [15:0] cap);
    return (rem > cap) ? cap : rem;
  endfunction

endpackage

// File: rtl/upstream_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NREQ.
module upstream_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic            found_o,
  output logic [2:0]      idx_o
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = 3'd0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_i[i] && (i == (int'(ptr_i) + off) % NREQ)) begin
          found_o = 1'b1;
          idx_o   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/upstream_sched.sv
// Round-robin scheduler sharing one upstream busif among NREQ DMA requesters,
// splitting each request into chunks of at most MAX_CHUNK bytes.
module upstream_sched
  import upstream_pkg::*;
#(
  parameter int NREQ      = NREQ_DEFAULT,
  parameter int MAX_CHUNK = MAX_CHUNK_DEFAULT,
  parameter int PAUSE_THR = PAUSE_THR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*16-1:0] req_len,
  output logic [NREQ-1:0]    req_ack,
  output logic               busy,
  output logic [2:0]         grant_id,
  input  logic [7:0]         fifo_space,
  output logic               bif_start,
  output logic               bif_pause,
  input  logic               bif_done,
  output logic [31:0]        bif_addr,
  output logic [15:0]        bif_length,
  output sched_state_e       dbg_state_o
);

  localparam logic [15:0] CHUNK_CAP   = 16'(MAX_CHUNK);
  localparam logic [8:0]  PAUSE_LIMIT = 9'(PAUSE_THR);

  sched_state_e    state_q;
  logic [2:0]      rr_ptr_q;
  logic [2:0]      grant_id_q;
  logic            busy_q;
  logic [NREQ-1:0] req_ack_q;
  logic [31:0]     cur_addr_q;
  logic [15:0]     rem_q;
  logic [15:0]     chunk_q;
  logic            bif_start_q;
  logic            bif_pause_q;
  logic [31:0]     bif_addr_q;
  logic [15:0]     bif_length_q;

  logic            arb_found;
  logic [2:0]      arb_idx;
  logic [31:0]     sel_addr;
  logic [15:0]     sel_len;
  logic [15:0]     chunk_d;
  logic [NREQ-1:0] ack_onehot;
  logic [2:0]      rr_ptr_d;

  upstream_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  always_comb begin
    sel_addr   = '0;
    sel_len    = '0;
    ack_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == 3'(i)) begin
        sel_addr = req_addr[32*i +: 32];
        sel_len  = req_len[16*i +: 16];
      end
      ack_onehot[i] = (grant_id_q == 3'(i));
    end
  end

  assign chunk_d  = chunk_of(rem_q, CHUNK_CAP);
  assign rr_ptr_d = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;

  // Busif handshake: bif_start is a level held until bif_done rises; the next
  // start may only follow once bif_done has been seen low again (CLR), and
  // bif_addr/bif_length only change in LOAD, so they are stable throughout.
  // The IDLE cycle in which req_ack is visible does not arbitrate, giving the
  // acked requester one cycle to drop req_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      req_ack_q    <= '0;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      chunk_q      <= '0;
      bif_start_q  <= 1'b0;
      bif_pause_q  <= 1'b0;
      bif_addr_q   <= '0;
      bif_length_q <= '0;
    end else begin
      bif_pause_q <= ({1'b0, fifo_space} < PAUSE_LIMIT);
      req_ack_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_found && (req_ack_q == '0)) begin
            cur_addr_q <= sel_addr;
            rem_q      <= sel_len;
            grant_id_q <= arb_idx;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (rem_q == '0) begin
            state_q <= ST_ACK;
          end else if (!bif_done) begin
            chunk_q      <= chunk_d;
            bif_addr_q   <= cur_addr_q;
            bif_length_q <= chunk_d;
            bif_start_q  <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bif_done) begin
            bif_start_q <= 1'b0;
            cur_addr_q  <= cur_addr_q + {16'd0, chunk_q};
            rem_q       <= rem_q - chunk_q;
            state_q     <= ST_CLR;
          end
        end
        ST_CLR: begin
          if (!bif_done) begin
            state_q <= (rem_q != '0) ? ST_LOAD : ST_ACK;
          end
        end
        ST_ACK: begin
          req_ack_q <= ack_onehot;
          busy_q    <= 1'b0;
          rr_ptr_q  <= rr_ptr_d;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ack     = req_ack_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign bif_start   = bif_start_q;
  assign bif_pause   = bif_pause_q;
  assign bif_addr    = bif_addr_q;
  assign bif_length  = bif_length_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_upstream_sched.sv
// Bench for upstream_sched: busif responder, requester models and a
// transfer-level reference model driven from one thread at the falling edge.
module tb_upstream_sched;
  import upstream_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_CHUNK = 2048;
  localparam int PAUSE_THR = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*16-1:0] req_len;
  logic [NREQ-1:0]    req_ack;
  logic               busy;
  logic [2:0]         grant_id;
  logic [7:0]         fifo_space = 8'd10;
  logic               bif_start;
  logic               bif_pause;
  logic               bif_done = 1'b0;
  logic [31:0]        bif_addr;
  logic [15:0]        bif_length;
  sched_state_e       dbg_state;

  logic [31:0] d_addr [NREQ];
  logic [15:0] d_len  [NREQ];

  always_comb begin
    req_addr = '0;
    req_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[32*i +: 32] = d_addr[i];
      req_len[16*i +: 16]  = d_len[i];
    end
  end

  upstream_sched #(.NREQ(NREQ), .MAX_CHUNK(MAX_CHUNK), .PAUSE_THR(PAUSE_THR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_ack     (req_ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .fifo_space  (fifo_space),
    .bif_start   (bif_start),
    .bif_pause   (bif_pause),
    .bif_done    (bif_done),
    .bif_addr    (bif_addr),
    .bif_length  (bif_length),
    .dbg_state_o (dbg_state)
  );

  // scoreboard and model state
  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[$];
  logic [47:0] cur_exp = '0;
  int grant_log[$];
  int m_ptr = 0;
  int cur_gid = 0;
  int n_starts = 0;
  int n_acks [NREQ];
  logic prev_busy = 1'b0, prev_ack_any = 1'b0, prev_start = 1'b0, prev_done = 1'b0;
  logic [NREQ-1:0] drop_q = '0;
  logic hold_mode = 1'b0;
  int bm_lat = 3, bm_hold = 0, bm_cnt = 0, bm_left = 0;
  logic bm_active = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_chunks(input int id);
    logic [31:0] a;
    int l;
    a = d_addr[id];
    l = int'(d_len[id]);
    while (l > 0) begin
      int c;
      c = (l > MAX_CHUNK) ? MAX_CHUNK : l;
      exp_q.push_back({a, 16'(c)});
      a = a + 32'(c);
      l = l - c;
    end
  endtask

  task automatic monitor();
    int exp_id;
    logic [NREQ-1:0] exp_ack;
    if (!rst_n) begin
      prev_busy = 1'b0; prev_ack_any = 1'b0; prev_start = 1'b0; prev_done = 1'b0;
      exp_q.delete();
      m_ptr = 0;
      return;
    end
    check_eq("pause", bif_pause, fifo_space < 8'(PAUSE_THR));
    if (prev_ack_any) begin
      check_eq("no_regrant_in_ack_cycle", busy, 1'b0);
    end else if (!prev_busy) begin
      exp_id = rr_pick(req_valid, m_ptr);
      check_eq("arb_busy", busy, exp_id >= 0);
      if (busy && exp_id >= 0) begin
        check_eq("grant_id", grant_id, exp_id);
        grant_log.push_back(int'(grant_id));
        cur_gid = exp_id;
        push_chunks(exp_id);
      end
    end else if (busy) begin
      check_eq("grant_hold", grant_id, cur_gid);
    end
    exp_ack = '0;
    if (prev_busy && !busy) exp_ack[cur_gid] = 1'b1;
    check_eq("req_ack", req_ack, exp_ack);
    if (prev_busy && !busy) begin
      check_eq("chunks_left_at_ack", exp_q.size(), 0);
      check_eq("bif_quiet_at_ack", {bif_start, bif_done}, 2'b00);
      m_ptr = (cur_gid + 1) % NREQ;
      n_acks[cur_gid]++;
    end
    if (bif_start && !prev_start) begin
      n_starts++;
      check_eq("start_gap_after_done", {prev_done, bif_done}, 2'b00);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_start", 1'b1, 1'b0);
      end else begin
        cur_exp = exp_q.pop_front();
        check_eq("xfer_addr_len", {bif_addr, bif_length}, cur_exp);
      end
    end else if (bif_start || bif_done) begin
      check_eq("xfer_stable", {bif_addr, bif_length}, cur_exp);
    end
    prev_busy    = busy;
    prev_ack_any = |req_ack;
    prev_start   = bif_start;
    prev_done    = bif_done;
  endtask

  task automatic busif_step();
    if (!rst_n) begin
      bif_done = 1'b0; bm_active = 1'b0;
      return;
    end
    if (!bif_done) begin
      if (bif_start) begin
        if (!bm_active) begin bm_active = 1'b1; bm_cnt = bm_lat; end
        if (bm_cnt == 0) begin bif_done = 1'b1; bm_left = bm_hold; end
        else bm_cnt--;
      end
    end else if (!bif_start) begin
      if (bm_left == 0) begin bif_done = 1'b0; bm_active = 1'b0; end
      else bm_left--;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    busif_step();
    req_valid = req_valid & ~drop_q;
    drop_q = hold_mode ? '0 : req_ack;
  endtask

  // driver tasks
  task automatic post(input int id, input logic [31:0] a, input logic [15:0] l);
    d_addr[id] = a;
    d_len[id]  = l;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((req_valid != '0 || busy || bif_start || bif_done || req_ack != '0) && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, k < budget, 1'b1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int k = 0;
    while (!bif_start && k < budget) begin tick(); k++; end
    check_eq(tag, k < budget, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, {req_ack, busy, grant_id, bif_start, bif_pause, bif_addr, bif_length}, '0);
  endtask

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  task automatic hold_all_grants(input int n, input string tag);
    int k = 0;
    int base = grant_log.size();
    for (int i = 0; i < NREQ; i++) post(i, 32'h5000 + 32'(i) * 32'h100, 16'd16);
    hold_mode = 1'b1;
    while (grant_log.size() < base + n && k < 600) begin tick(); k++; end
    check_eq({tag, "_timeout"}, k < 600, 1'b1);
    hold_mode = 1'b0;
    wait_idle(600, {tag, "_drain"});
  endtask

  initial begin
    int base, n0, nb, ack_at, np, first_p;
    int exp_a[5], exp_b[4];
    for (int i = 0; i < NREQ; i++) begin d_addr[i] = '0; d_len[i] = '0; n_acks[i] = 0; end

    // reset state
    tick(); tick();
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    // single 64-byte request
    bm_lat = 10; n0 = n_starts;
    post(0, 32'h1000, 16'd64);
    wait_idle(200, "single_timeout");
    check_eq("single_starts", n_starts - n0, 1);
    check_eq("single_acks", n_acks[0], 1);

    // 5000 bytes from an unaligned address: three chunks
    bm_lat = 2; n0 = n_starts;
    post(0, 32'h2003, 16'd5000);
    wait_idle(300, "split_timeout");
    check_eq("split_starts", n_starts - n0, 3);
    check_eq("split_acks", n_acks[0], 2);

    // round robin from pointer 0, then from pointer 2
    post(3, 32'h3000, 16'd8);
    wait_idle(200, "rr_prep0");
    base = grant_log.size();
    hold_all_grants(5, "rr_from0");
    exp_a = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) check_eq($sformatf("rr_from0_%0d", k), log_at(base + k), exp_a[k]);
    while (m_ptr != 1) begin
      post(m_ptr, 32'h3100, 16'd8);
      wait_idle(200, "rr_prep_align");
    end
    post(1, 32'h3200, 16'd8);
    wait_idle(200, "rr_prep2");
    base = grant_log.size();
    hold_all_grants(4, "rr_from2");
    exp_b = '{2, 3, 0, 1};
    for (int k = 0; k < 4; k++) check_eq($sformatf("rr_from2_%0d", k), log_at(base + k), exp_b[k]);

    // zero-length request
    n0 = n_starts; nb = 0; ack_at = 0;
    post(1, 32'h7777, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (busy) nb++;
      if (req_ack[1]) ack_at = k;
    end
    check_eq("len0_busy_cycles", nb, 2);
    check_eq("len0_ack_latency", ack_at, 3);
    wait_idle(50, "len0_timeout");
    check_eq("len0_no_start", n_starts - n0, 0);

    // pause follows fifo_space one cycle late
    bm_lat = 20;
    post(2, 32'h4000, 16'd64);
    wait_start(50, "pause_wait_start");
    fifo_space = 8'd3; np = 0; first_p = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bif_pause) begin np++; if (first_p == 0) first_p = k; end
      if (k == 5) fifo_space = 8'd10;
    end
    check_eq("pause_cycles", np, 5);
    check_eq("pause_delay", first_p, 1);
    wait_idle(200, "pause_timeout");

    // asynchronous reset mid-transfer
    bm_lat = 3;
    post(1, 32'h6000, 16'd16);
    wait_idle(200, "rst_prep");
    bm_lat = 30;
    post(2, 32'h8000, 16'd4096);
    post(0, 32'h9000, 16'd32);
    wait_start(50, "rst_wait_start");
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset_outputs");
    tick(); tick();
    rst_n = 1'b1;
    base = grant_log.size();
    bm_lat = 4;
    wait_idle(1000, "rst_after_timeout");
    check_eq("rst_regrant_first", log_at(base), 0);
    check_eq("rst_regrant_second", log_at(base + 1), 2);

    // busif holds done for 5 cycles after start drops
    bm_lat = 3; bm_hold = 5; n0 = n_starts;
    post(3, 32'h0100, 16'd5000);
    wait_idle(400, "done_hold_timeout");
    check_eq("done_hold_starts", n_starts - n0, 3);

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      int id;
      int r;
      fifo_space = 8'($urandom_range(0, 12));
      bm_lat  = $urandom_range(0, 6);
      bm_hold = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        id = $urandom_range(0, NREQ - 1);
        if (!req_valid[id]) begin
          r = $urandom_range(0, 9);
          post(id, $urandom, (r == 0) ? 16'd0 :
                             (r == 1) ? 16'($urandom_range(2049, 6000)) :
                                        16'($urandom_range(1, 300)));
        end
      end
      tick();
    end
    fifo_space = 8'd10;
    wait_idle(20000, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
